// File: rtl/frob_sched_pkg.sv
// Shared types and elaboration-time helpers for the Frobenius-norm scheduler.
package frob_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitSum,
        StSqrt,
        StDone
    } frob_state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned calc_n(input int unsigned a, input int unsigned b);
        return a * b;
    endfunction

    // Issue-relative cycle carrying sqrt_en.
    function automatic int unsigned calc_t_sqrt(input int unsigned a, input int unsigned b,
                                                input int unsigned m, input int unsigned acc);
        return calc_n(a, b) - 1 + m + acc;
    endfunction

    // Issue-relative cycle carrying done.
    function automatic int unsigned calc_t_done(input int unsigned a, input int unsigned b,
                                                input int unsigned m, input int unsigned acc,
                                                input int unsigned s);
        return calc_t_sqrt(a, b, m, acc) + s;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b,
                                          input int unsigned m, input int unsigned acc,
                                          input int unsigned s);
        return idx_w(calc_t_done(a, b, m, acc, s) + 1);
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit valid pipeline with async clear and synchronous flush (DEPTH >= 1).
module valid_delay_line #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic in_i,
    output logic out_o
);

    logic [DEPTH-1:0] sr_q, sr_d;

    generate
        if (DEPTH == 1) begin : g_single
            assign sr_d = in_i;
        end else begin : g_multi
            assign sr_d = {sr_q[DEPTH-2:0], in_i};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else if (flush_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign out_o = sr_q[DEPTH-1];

endmodule

// File: rtl/frobenius_norm_scheduler.sv
// Round-robin sequencer for a shared serial Frobenius-norm datapath (mult -> acc -> sqrt).
// Optional mid-job abort on req deassertion: define FROB_SCHED_ABORT_EN.
module frobenius_norm_scheduler
    import frob_sched_pkg::*;
#(
    parameter int unsigned SIZE_A   = 8,
    parameter int unsigned SIZE_B   = 8,
    parameter int unsigned CYCLES_M = 5,
    parameter int unsigned CYCLES_A = 7,
    parameter int unsigned CYCLES_S = 30,
    parameter int unsigned NUM_REQ  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [idx_w(SIZE_A)-1:0]   row_idx,
    output logic [idx_w(SIZE_B)-1:0]   col_idx,
    output logic                       mult_en,
    output logic                       acc_en,
    output logic                       acc_new,
    output logic                       sqrt_en,
    input  logic                       unit_flag,
    output logic [NUM_REQ-1:0]         done,
    output logic                       err,
    output logic                       busy
);

    localparam int unsigned RowW = idx_w(SIZE_A);
    localparam int unsigned ColW = idx_w(SIZE_B);
    localparam int unsigned PtrW = idx_w(NUM_REQ);
    localparam int unsigned CntW = cnt_w(SIZE_A, SIZE_B, CYCLES_M, CYCLES_A, CYCLES_S);

    localparam logic [CntW-1:0] LastIssue = CntW'(calc_n(SIZE_A, SIZE_B) - 1);
    localparam logic [CntW-1:0] SqrtAt    = CntW'(calc_t_sqrt(SIZE_A, SIZE_B, CYCLES_M, CYCLES_A));
    localparam logic [CntW-1:0] SqrtLast  =
        CntW'(calc_t_done(SIZE_A, SIZE_B, CYCLES_M, CYCLES_A, CYCLES_S) - 1);
    localparam logic [ColW-1:0] ColLast   = ColW'(SIZE_B - 1);
    localparam logic [PtrW-1:0] PtrLast   = PtrW'(NUM_REQ - 1);

    frob_state_t       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PtrW-1:0]   gidx_q, gidx_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic              err_q, err_d;

    logic              flush;
    logic              issue_first;
    logic              in_job;
    logic              found;
    logic [PtrW-1:0]   pick;
    logic [PtrW-1:0]   scan;

    function automatic logic [PtrW-1:0] next_idx(input logic [PtrW-1:0] i);
        return (i == PtrLast) ? '0 : i + 1'b1;
    endfunction

    // First requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        scan  = ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[scan]) begin
                pick  = scan;
                found = 1'b1;
            end
            scan = next_idx(scan);
        end
    end

    assign in_job      = (state_q == StIssue) || (state_q == StWaitSum) || (state_q == StSqrt);
    assign issue_first = (state_q == StIssue) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        sqrt_en = 1'b0;
        flush   = 1'b0;

        // Error window opens with the first product reaching the accumulator.
        if (acc_en || state_q == StWaitSum || state_q == StSqrt) begin
            err_d = err_q | unit_flag;
        end

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StIssue;
                    gnt_d   = NUM_REQ'(1) << pick;
                    gidx_d  = pick;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StIssue: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIssue) begin
                    state_d = StWaitSum;
                    row_d   = '0;
                    col_d   = '0;
                end else if (col_q == ColLast) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StWaitSum: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SqrtAt) begin
                    sqrt_en = 1'b1;
                    state_d = (CYCLES_S <= 1) ? StDone : StSqrt;
                end
            end
            StSqrt: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SqrtLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                gnt_d   = '0;
                ptr_d   = next_idx(gidx_q);
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase

`ifdef FROB_SCHED_ABORT_EN
        if (in_job && !req[gidx_q]) begin
            state_d = StIdle;
            gnt_d   = '0;
            ptr_d   = next_idx(gidx_q);
            cnt_d   = '0;
            row_d   = '0;
            col_d   = '0;
            err_d   = 1'b0;
            sqrt_en = 1'b0;
            flush   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    valid_delay_line #(
        .DEPTH(CYCLES_M)
    ) u_acc_en_dly (
        .clk_i  (clk),
        .rst_ni (rst),
        .flush_i(flush),
        .in_i   (mult_en),
        .out_o  (acc_en)
    );

    valid_delay_line #(
        .DEPTH(CYCLES_M)
    ) u_acc_new_dly (
        .clk_i  (clk),
        .rst_ni (rst),
        .flush_i(flush),
        .in_i   (issue_first),
        .out_o  (acc_new)
    );

    assign mult_en = (state_q == StIssue);
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone) ? gnt_q : '0;
    assign gnt     = gnt_q;
    assign row_idx = row_q;
    assign col_idx = col_q;
    assign err     = err_q;

endmodule

// File: tb/tb_frobenius_norm_scheduler.sv
// Directed bench: default 8x8 instance plus a 2x3 instance with unit latencies.
module tb_frobenius_norm_scheduler;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [2:0] row_idx;
    logic [2:0] col_idx;
    logic       mult_en, acc_en, acc_new, sqrt_en, unit_flag, err, busy;
    logic [1:0] done;

    logic [1:0] req_s;
    logic [1:0] gnt_s;
    logic [0:0] row_s;
    logic [1:0] col_s;
    logic       mult_en_s, acc_en_s, acc_new_s, sqrt_en_s, err_s, busy_s;
    logic [1:0] done_s;

    int n_tests = 0;
    int n_fail  = 0;

    frobenius_norm_scheduler u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .row_idx  (row_idx),
        .col_idx  (col_idx),
        .mult_en  (mult_en),
        .acc_en   (acc_en),
        .acc_new  (acc_new),
        .sqrt_en  (sqrt_en),
        .unit_flag(unit_flag),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    frobenius_norm_scheduler #(
        .SIZE_A  (2),
        .SIZE_B  (3),
        .CYCLES_M(1),
        .CYCLES_A(1),
        .CYCLES_S(1),
        .NUM_REQ (2)
    ) u_small (
        .clk      (clk),
        .rst      (rst),
        .req      (req_s),
        .gnt      (gnt_s),
        .row_idx  (row_s),
        .col_idx  (col_s),
        .mult_en  (mult_en_s),
        .acc_en   (acc_en_s),
        .acc_new  (acc_new_s),
        .sqrt_en  (sqrt_en_s),
        .unit_flag(1'b0),
        .done     (done_s),
        .err      (err_s),
        .busy     (busy_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one 8x8 job from grant to done; flag_k < 0 means no unit_flag pulse.
    task automatic run_job(input int who, input int flag_k, input logic exp_err);
        logic [1:0] exp_g;
        int w, k, mult_cnt, acc_cnt, acc_first, new_cnt, new_k, sqrt_cnt, sqrt_k;
        int idx_bad, gnt_bad, done_k;
        logic [1:0] done_v;
        logic err_v, mult_at_done, got;
        exp_g = 2'b01 << who;
        w = 0;
        while (gnt === 2'b00 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("grant", 32'(gnt), 32'(exp_g));
        k = 0; mult_cnt = 0; acc_cnt = 0; acc_first = -1; new_cnt = 0; new_k = -1;
        sqrt_cnt = 0; sqrt_k = -1; idx_bad = 0; gnt_bad = 0; done_k = -1;
        done_v = 2'b00; err_v = 1'b0; mult_at_done = 1'b1; got = 1'b0;
        while (!got && k < 300) begin
            unit_flag = (k == flag_k);
            if (mult_en === 1'b1) begin
                mult_cnt++;
                if (int'(row_idx) != k / 8 || int'(col_idx) != k % 8) idx_bad++;
            end
            if (acc_en === 1'b1) begin
                if (acc_first < 0) acc_first = k;
                acc_cnt++;
            end
            if (acc_new === 1'b1) begin
                new_cnt++;
                new_k = k;
            end
            if (sqrt_en === 1'b1) begin
                sqrt_cnt++;
                sqrt_k = k;
            end
            if (gnt !== exp_g || busy !== 1'b1) gnt_bad++;
            if (done !== 2'b00) begin
                got = 1'b1;
                done_k = k;
                done_v = done;
                err_v = err;
                mult_at_done = mult_en;
                req[who] = 1'b0;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        unit_flag = 1'b0;
        chk("done_cycle", 32'(done_k), 32'd105);
        chk("done_vec", 32'(done_v), 32'(exp_g));
        chk("err_at_done", 32'(err_v), 32'(exp_err));
        chk("mult_en_count", 32'(mult_cnt), 32'd64);
        chk("index_errors", 32'(idx_bad), 32'd0);
        chk("acc_en_first", 32'(acc_first), 32'd5);
        chk("acc_en_count", 32'(acc_cnt), 32'd64);
        chk("acc_new_count", 32'(new_cnt), 32'd1);
        chk("acc_new_cycle", 32'(new_k), 32'd5);
        chk("sqrt_en_count", 32'(sqrt_cnt), 32'd1);
        chk("sqrt_en_cycle", 32'(sqrt_k), 32'd75);
        chk("gnt_busy_held", 32'(gnt_bad), 32'd0);
        chk("no_overlap_at_done", 32'(mult_at_done), 32'd0);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("gnt_after_done", 32'(gnt), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int k, w, mc, bad, nk, sk, dk;
        logic got;
        rst = 1'b0;
        req = 2'b00;
        req_s = 2'b00;
        unit_flag = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mult_en", 32'(mult_en), 32'd0);
        chk("rst_acc_en", 32'(acc_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_row", 32'(row_idx), 32'd0);
        rst = 1'b1;

        // Flag outside a job must not leak into the next result.
        unit_flag = 1'b1;
        @(negedge clk);
        unit_flag = 1'b0;

        // Contention from reset: 0 then 1.
        req = 2'b11;
        run_job(0, -1, 1'b0);
        run_job(1, -1, 1'b0);

        // Round robin back to 0; error in first job only.
        req = 2'b11;
        run_job(0, 40, 1'b1);
        run_job(1, -1, 1'b0);

        // Reset during WAIT_SUM.
        req = 2'b01;
        w = 0;
        while (gnt === 2'b00 && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (70) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mult_en", 32'(mult_en), 32'd0);
        chk("midrst_acc_en", 32'(acc_en), 32'd0);
        chk("midrst_acc_new", 32'(acc_new), 32'd0);
        chk("midrst_sqrt_en", 32'(sqrt_en), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_row_col", 32'({row_idx, col_idx}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_job(0, -1, 1'b0);

`ifdef FROB_SCHED_ABORT_EN
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req = 2'b11;
        w = 0;
        while (gnt === 2'b00 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("abort_grant", 32'(gnt), 32'd1);
        repeat (20) @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mult_en", 32'(mult_en), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("abort_next_grant", 32'(gnt), 32'd2);
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
`endif

        // Small instance: 2x3, unit latencies; done at 6-1+1+1+1 = 8.
        req_s = 2'b01;
        w = 0;
        while (gnt_s === 2'b00 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("small_grant", 32'(gnt_s), 32'd1);
        k = 0; mc = 0; bad = 0; nk = -1; sk = -1; dk = -1; got = 1'b0;
        while (!got && k < 50) begin
            if (mult_en_s === 1'b1) begin
                mc++;
                if (int'(row_s) != k / 3 || int'(col_s) != k % 3) bad++;
            end
            if (acc_new_s === 1'b1) nk = k;
            if (sqrt_en_s === 1'b1) sk = k;
            if (done_s !== 2'b00) begin
                got = 1'b1;
                dk = k;
                req_s = 2'b00;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk("small_mult_count", 32'(mc), 32'd6);
        chk("small_index_wrap", 32'(bad), 32'd0);
        chk("small_acc_new", 32'(nk), 32'd1);
        chk("small_sqrt_en", 32'(sk), 32'd7);
        chk("small_done", 32'(dk), 32'd8);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
